// File: rtl/mult16_signed.sv
// mult16_signed: 2-stage radix-4 Booth / Wallace 16x16 -> 32 two's-complement multiplier; MULT16_UNSIGNED_EN adds sgn (0 = unsigned operands)
module mult16_signed (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
`ifdef MULT16_UNSIGNED_EN
  input  logic        sgn,
`endif
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out,
  output logic        out_valid
);
`ifdef MULT16_UNSIGNED_EN
  localparam int NP = 9;
  localparam int AW = 17;
  logic sgn_r;
`else
  localparam int NP = 8;
  localparam int AW = 16;
`endif
  logic [15:0] a_r, b_r;
  logic v_r;
  logic [AW-1:0] ae;
  logic [2*NP:0] bx;
  logic [AW:0] mag, mx;
  logic one, two, neg;
  logic [31:0] cor, prod;
  logic [31:0] rows [10];
  logic [63:0] t1a, t1b, t1c, t2a, t2b, t3, t4, t5;
  function automatic logic [63:0] csa(input logic [31:0] x, y, z);
    return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
  endfunction
`ifdef MULT16_UNSIGNED_EN
  assign ae = {sgn_r & a_r[15], a_r};
  assign bx = {{2{sgn_r & b_r[15]}}, b_r, 1'b0};
`else
  assign ae = a_r;
  assign bx = {b_r, 1'b0};
`endif
  always_comb begin
    rows = '{default: '0};
    cor = '0;
    one = 1'b0;
    two = 1'b0;
    neg = 1'b0;
    mag = '0;
    mx = '0;
    for (int i = 0; i < NP; i++) begin
      one = bx[2*i] ^ bx[2*i+1];
      two = (bx[2*i+2] ^ bx[2*i+1]) & ~(bx[2*i+1] ^ bx[2*i]);
      neg = bx[2*i+2] & ~(bx[2*i+1] & bx[2*i]);
      mag = one ? {ae[AW-1], ae} : two ? {ae, 1'b0} : '0;
      mx = neg ? ~mag : mag;
      rows[i] = {{(31-AW){mx[AW]}}, mx} << (2*i);
      cor[2*i] = neg;
    end
    rows[NP] = cor;
  end
  assign t1a = csa(rows[0], rows[1], rows[2]);
  assign t1b = csa(rows[3], rows[4], rows[5]);
  assign t1c = csa(rows[6], rows[7], rows[8]);
  assign t2a = csa(t1a[31:0], t1a[63:32], t1b[31:0]);
  assign t2b = csa(t1b[63:32], t1c[31:0], t1c[63:32]);
  assign t3 = csa(t2a[31:0], t2a[63:32], t2b[31:0]);
  assign t4 = csa(t3[31:0], t3[63:32], t2b[63:32]);
  assign t5 = csa(t4[31:0], t4[63:32], rows[9]);
  assign prod = t5[31:0] + t5[63:32];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      v_r <= 1'b0;
`ifdef MULT16_UNSIGNED_EN
      sgn_r <= 1'b0;
`endif
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      a_r <= a;
      b_r <= b;
      v_r <= in_valid;
`ifdef MULT16_UNSIGNED_EN
      sgn_r <= sgn;
`endif
      out <= prod;
      out_valid <= v_r;
    end
endmodule

// File: tb/tb_mult16_signed.sv
// tb_mult16_signed: directed-vector bench for mult16_signed with a two-deep expected-result pipeline
module tb_mult16_signed;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] out;
  logic out_valid;
`ifdef MULT16_UNSIGNED_EN
  logic sgn = 1'b1;
`endif
  int n_run = 0, n_fail = 0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [31:0] e1 = '0, e2 = '0;
  string t1 = "", t2 = "";
  logic [15:0] x, y;
  always #5 clk = ~clk;
  mult16_signed dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
`ifdef MULT16_UNSIGNED_EN
    .sgn(sgn),
`endif
    .a(a),
    .b(b),
    .out(out),
    .out_valid(out_valid)
  );
  function automatic logic [31:0] smul(input logic [15:0] p, q);
    return $signed({{16{p[15]}}, p}) * $signed({{16{q[15]}}, q});
  endfunction
  task automatic check(input string tag, input logic [31:0] got, exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] p, q, input logic [31:0] e, input string tag);
    check({t2, "/vld"}, 32'(out_valid), 32'(v2));
    if (v2) check(t2, out, e2);
    v2 = v1;
    e2 = e1;
    t2 = t1;
    v1 = v;
    e1 = e;
    t1 = tag;
    in_valid = v;
    a = p;
    b = q;
    @(negedge clk);
  endtask
  initial begin
    #3;
    a = 16'h1234;
    b = 16'hbeef;
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_async_out", out, 32'h0);
    check("rst_async_vld", 32'(out_valid), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_hold_out", out, 32'h0);
    check("rst_hold_vld", 32'(out_valid), 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    cyc(1'b1, 16'h0000, 16'h0000, 32'h00000000, "zero");
    cyc(1'b1, 16'h0001, 16'hffff, 32'hffffffff, "one_neg1");
    cyc(1'b1, 16'hffff, 16'hffff, 32'h00000001, "neg1_neg1");
    cyc(1'b1, 16'h8000, 16'h8000, 32'h40000000, "min_min");
    cyc(1'b1, 16'h8000, 16'h7fff, 32'hc0008000, "min_max");
    cyc(1'b1, 16'h7fff, 16'h7fff, 32'h3fff0001, "max_max");
    cyc(1'b1, 16'h0003, 16'h0005, 32'h0000000f, "3x5");
    cyc(1'b1, 16'hfffd, 16'h0005, 32'hfffffff1, "m3x5");
    cyc(1'b1, 16'h1234, 16'h0010, 32'h00012340, "shift4");
    cyc(1'b1, 16'hfffe, 16'h8000, 32'h00010000, "m2xmin");
    cyc(1'b1, 16'h7fff, 16'hffff, 32'hffff8001, "maxxm1");
    cyc(1'b1, 16'h0064, 16'hff9c, 32'hffffd8f0, "100xm100");
    cyc(1'b1, 16'h00ff, 16'h0100, 32'h0000ff00, "ffx100");
    cyc(1'b0, 16'h5555, 16'haaaa, 32'h0, "bubble0");
    cyc(1'b0, 16'h0000, 16'h0000, 32'h0, "bubble1");
    for (int i = 0; i < 100; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      cyc(1'b1, x, y, smul(x, y), $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      repeat (2) cyc(1'b1, x, y, smul(x, y), $sformatf("hold%0d", i));
    end
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "drain0");
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "drain1");
    cyc(1'b1, 16'h0003, 16'h0005, 32'h0000000f, "lost0");
    cyc(1'b1, 16'h0007, 16'h0007, 32'h00000031, "lost1");
    #1 rst = 1'b1;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_vld", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    cyc(1'b0, 16'h0003, 16'h0005, 32'h0, "idle0");
    cyc(1'b0, 16'h0003, 16'h0005, 32'h0, "idle1");
    cyc(1'b1, 16'hfffd, 16'h0005, 32'hfffffff1, "post_rst");
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "idle2");
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "idle3");
`ifdef MULT16_UNSIGNED_EN
    sgn = 1'b0;
    cyc(1'b1, 16'hffff, 16'hffff, 32'hfffe0001, "u_ffff");
    cyc(1'b1, 16'hffff, 16'h0002, 32'h0001fffe, "u_x2");
    cyc(1'b1, 16'h8000, 16'h8000, 32'h40000000, "u_min");
    sgn = 1'b1;
    cyc(1'b1, 16'hffff, 16'hffff, 32'h00000001, "s_ffff");
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "udrain0");
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "udrain1");
`endif
    cyc(1'b0, 16'h0, 16'h0, 32'h0, "end");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
